adder_bist_checker: RTL and testbench

- Hardware self-test engine for the full-adder datapath.
- Generates every operand/carry-in combination exhaustively and drives it into the adder under test.
- Samples the adder's sum and carry-out after a programmable settle time and compares them against an internally computed golden result.
- Reports pass/fail, a saturating error count and the first failing vector.

---
 rtl/adder_bist_checker.sv | 114 +++++++++++
 tb/tb_adder_bist_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist_checker.sv
// Self-test engine for the full-adder datapath. It walks every {a,b,cin}
// combination, lets the adder settle, and checks the adder's response
// against a locally computed golden sum. It reports pass/fail, a saturating
// error count and the first failing vector.
module adder_bist_checker #(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_count,
    output logic               fail_valid,
    output logic [2*WIDTH:0]   fail_vec
);

    localparam int VW = 2*WIDTH + 1;
    // The settle counter is never narrower than one bit, so a zero settle time still gets a legal vector.
    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [SW-1:0]   settle_cnt;

    logic [WIDTH-1:0] va, vb;
    logic             vc;
    logic [WIDTH:0]   exp_res;
    logic             mismatch;
    logic [7:0]       err_next;

    // Golden result comes from vec, which always equals the registered dut_* fields while in CHECK.
    assign {va, vb, vc} = vec;
    assign exp_res      = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vc};
    assign mismatch     = ({dut_cout, dut_sum} != exp_res);

    // Next error count, saturating at 255.
    always_comb begin
        err_next = err_count;
        if (mismatch && (err_count != 8'hFF))
            err_next = err_count + 8'd1;
    end

    // Test sequencer: apply a vector, wait for it to settle, check it, then step to the next vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            dut_a      <= '0;
            dut_b      <= '0;
            dut_cin    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        vec        <= '0;
                        busy       <= 1'b1;
                        state      <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    {dut_a, dut_b, dut_cin} <= vec;
                    settle_cnt              <= SW'(SETTLE_CYCLES);
                    state                   <= (SETTLE_CYCLES == 0) ? S_CHECK : S_WAIT;
                end
                S_WAIT: begin
                    settle_cnt <= settle_cnt - SW'(1);
                    if (settle_cnt == SW'(1))
                        state <= S_CHECK;
                end
                S_CHECK: begin
                    err_count <= err_next;
                    // Only the first failure of a run is captured.
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                    end
                    if (&vec) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                    end else begin
                        vec   <= vec + VW'(1);
                        state <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker. The default-parameter instance drives an
// adder with selectable faults and is compared every cycle against a
// vector-level model of the run. Three extra instances cover zero settle
// time, a wider operand, and error-count saturation.
module tb_adder_bist_checker;

    logic clk;
    logic rst_n;
    logic start0, startx;
    int   fm;
    int   checks, failures;
    int   k;
    bit   trk;

    localparam int P0 = 4;   // cycles per vector at SETTLE_CYCLES=2
    localparam int N0 = 8;   // vectors at WIDTH=1

    // Main instance: WIDTH=1, SETTLE_CYCLES=2.
    logic       a0, b0, c0, s0, co0, busy0, done0, pass0, fv0;
    logic [7:0] err0;
    logic [2:0] fvec0;

    // Extra instances.
    logic       a1, b1, c1, s1, co1, busy1, done1, pass1, fv1;
    logic [7:0] err1;
    logic [2:0] fvec1;
    logic [1:0] a2, b2, s2;
    logic       c2, co2, busy2, done2, pass2, fv2;
    logic [7:0] err2;
    logic [4:0] fvec2;
    logic [3:0] a3, b3, s3;
    logic       c3, co3, busy3, done3, pass3, fv3;
    logic [7:0] err3;
    logic [8:0] fvec3;
    logic [4:0] r3;

    // Adder under test with fault modes: 0 healthy, 1 cout stuck at 0, 2 sum inverted.
    function automatic logic [1:0] resp1(input logic a, input logic b, input logic c, input int m);
        logic [1:0] r;
        r = {1'b0, a} + {1'b0, b} + {1'b0, c};
        if (m == 1) r[1] = 1'b0;
        if (m == 2) r[0] = ~r[0];
        return r;
    endfunction

    assign {co0, s0} = resp1(a0, b0, c0, fm);
    assign {co1, s1} = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
    assign {co2, s2} = {1'b0, a2} + {1'b0, b2} + {2'b00, c2};
    assign r3        = {1'b0, a3} + {1'b0, b3} + {4'b0000, c3};
    assign s3        = r3[3:0] ^ 4'hF;
    assign co3       = r3[4];

    adder_bist_checker #(.WIDTH(1), .SETTLE_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .dut_a(a0), .dut_b(b0), .dut_cin(c0), .dut_sum(s0), .dut_cout(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .fail_vec(fvec0));

    adder_bist_checker #(.WIDTH(1), .SETTLE_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(startx),
        .dut_a(a1), .dut_b(b1), .dut_cin(c1), .dut_sum(s1), .dut_cout(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_vec(fvec1));

    adder_bist_checker #(.WIDTH(2), .SETTLE_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(startx),
        .dut_a(a2), .dut_b(b2), .dut_cin(c2), .dut_sum(s2), .dut_cout(co2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_vec(fvec2));

    adder_bist_checker #(.WIDTH(4), .SETTLE_CYCLES(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(startx),
        .dut_a(a3), .dut_b(b3), .dut_cin(c3), .dut_sum(s3), .dut_cout(co3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .fail_vec(fvec3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Does vector v = {a,b,cin} mismatch under the current fault mode?
    function automatic bit vfail(input int v);
        int a, b, c, g;
        logic [1:0] r;
        a = (v >> 2) & 1;
        b = (v >> 1) & 1;
        c = v & 1;
        g = a + b + c;
        r = resp1(a[0], b[0], c[0], fm);
        return (int'(r) != g);
    endfunction

    // Model check of the main instance. k counts cycles after the edge that sampled start.
    // Vector v is checked at edge (v+1)*P0 and applied from edge v*P0+1 onwards.
    always @(negedge clk) begin : mon
        int nchk, e, first, av;
        if (trk) begin
            if (k >= 0) begin
                nchk = k / P0;
                if (nchk > N0) nchk = N0;
                e = 0;
                first = 0;
                for (int v = 0; v < nchk; v++)
                    if (vfail(v)) begin
                        if (e == 0) first = v;
                        e++;
                    end
                if (e > 255) e = 255;
                chk("busy", busy0, k < N0*P0);
                chk("done", done0, k >= N0*P0);
                chk("pass", pass0, (k >= N0*P0) && (e == 0));
                chk("err_count", err0, e);
                chk("fail_valid", fv0, e > 0);
                chk("fail_vec", fvec0, first);
                if (k >= 1) begin
                    av = (k - 1) / P0;
                    if (av > N0 - 1) av = N0 - 1;
                    chk("applied_vec", {a0, b0, c0}, av);
                end
            end
            k++;
        end
    end

    // One run on the main instance; optionally re-pulses start mid-run.
    task automatic run0(input int exp_cyc, input bit repulse);
        int cyc;
        @(posedge clk); #1;
        start0 = 1'b1; k = -1; trk = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (done0) break;
            start0 = (repulse && cyc == 10);
        end
        start0 = 1'b0;
        chk("done_cycle", cyc, exp_cyc);
        repeat (3) @(posedge clk);
        #1 trk = 1'b0;
    endtask

    initial begin : main
        int d1, d2, d3;
        checks = 0; failures = 0;
        rst_n = 1'b1; start0 = 1'b0; startx = 1'b0; fm = 0; trk = 1'b0; k = -1;
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", {a0, b0, c0, busy0, done0, pass0, err0, fv0, fvec0}, 0);
        #20 rst_n = 1'b1;

        // Healthy adder.
        fm = 0;
        run0(32, 1'b0);
        chk("healthy_pass", pass0, 1);
        chk("healthy_err", err0, 0);
        chk("healthy_fv", fv0, 0);

        // cout stuck at 0: vectors 011,101,110,111 fail.
        fm = 1;
        run0(32, 1'b0);
        chk("cout0_err", err0, 4);
        chk("cout0_fvec", fvec0, 3);
        chk("cout0_fv", fv0, 1);
        chk("cout0_pass", pass0, 0);

        // Sum inverted, with an ignored start re-pulse mid-run; restarted from DONE.
        fm = 2;
        run0(32, 1'b1);
        chk("suminv_err", err0, 8);
        chk("suminv_fvec", fvec0, 0);
        chk("suminv_pass", pass0, 0);

        // Asynchronous reset while vector 100 is applied.
        fm = 1;
        @(posedge clk); #1;
        start0 = 1'b1; k = -1; trk = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (18) @(posedge clk);
        #1 trk = 1'b0;
        chk("vec_before_rst", {a0, b0, c0}, 3'b100);
        chk("err_before_rst", err0, 1);
        rst_n = 1'b0;
        #1 chk("midrun_reset_outputs", {a0, b0, c0, busy0, done0, pass0, err0, fv0, fvec0}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("idle_after_rst", {busy0, done0}, 0);

        fm = 0;
        run0(32, 1'b0);
        chk("after_rst_pass", pass0, 1);

        // Zero settle, wider operand, and saturation instances.
        @(posedge clk); #1 startx = 1'b1;
        @(posedge clk); #1 startx = 1'b0;
        d1 = 0; d2 = 0; d3 = 0;
        for (int cyc = 1; cyc <= 1100; cyc++) begin
            @(posedge clk); #1;
            if (done1 && d1 == 0) d1 = cyc;
            if (done2 && d2 == 0) d2 = cyc;
            if (done3 && d3 == 0) d3 = cyc;
            if (d1 != 0 && d2 != 0 && d3 != 0) break;
        end
        chk("s0_done_cycle", d1, 16);
        chk("s0_pass", pass1, 1);
        chk("s0_err", err1, 0);
        chk("w2_done_cycle", d2, 128);
        chk("w2_pass", pass2, 1);
        chk("w2_err", err2, 0);
        chk("w4_done_cycle", d3, 1024);
        chk("w4_err_sat", err3, 255);
        chk("w4_fv", fv3, 1);
        chk("w4_fvec", fvec3, 0);
        chk("w4_pass", pass3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
